// File: rtl/pca_pkg.sv
// Shared types and default sizes for the PCA projection / reconstruction stages.
package pca_pkg;

  localparam int DEF_FP_SIZE    = 64;
  localparam int DEF_PC_NUM     = 32;
  localparam int DEF_MIN_PC_NUM = 5;

  typedef logic [DEF_FP_SIZE-1:0] elem_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/recon_mac_lane.sv
// One reconstruction lane: accumulator with clear/enable and a truncating multiply-add.
module recon_mac_lane #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] acc
);

  logic [W-1:0] prod;

  // Product keeps only the low W bits; the sum wraps the same way.
  assign prod = a * b;

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod;
    end
  end

endmodule

// File: rtl/pca_reconstruct_mac.sv
// Rebuilds a PC_NUM-element vector from MIN_PC_NUM coefficients, one component per cycle.
module pca_reconstruct_mac
  import pca_pkg::*;
#(
  parameter int FP_SIZE    = DEF_FP_SIZE,
  parameter int PC_NUM     = DEF_PC_NUM,
  parameter int MIN_PC_NUM = DEF_MIN_PC_NUM
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FP_SIZE-1:0] coef_vector [0:MIN_PC_NUM-1],
  input  logic [FP_SIZE-1:0] basis       [0:MIN_PC_NUM-1][0:PC_NUM-1],
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FP_SIZE-1:0] out_vector  [0:PC_NUM-1],
  output logic               busy
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // valid never waits on ready, and the result is held while out_valid && !out_ready.

  localparam int IDX_W = (MIN_PC_NUM > 1) ? $clog2(MIN_PC_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MIN_PC_NUM - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [FP_SIZE-1:0] coef_r [0:MIN_PC_NUM-1];
  logic [FP_SIZE-1:0] coef_sel;
  logic               accept;
  logic               acc_en;
  logic               last;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    acc_en  = 1'b0;
    last    = (idx_q == LAST_IDX);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_en = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int i = 0; i < MIN_PC_NUM; i++) coef_r[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q  <= '0;
        coef_r <= coef_vector;
      end else if (acc_en && !last) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign coef_sel  = coef_r[idx_q];

  for (genvar j = 0; j < PC_NUM; j++) begin : g_lane
    recon_mac_lane #(.W(FP_SIZE)) u_lane (
      .clk   (clk),
      .reset (reset),
      .clr   (accept),
      .en    (acc_en),
      .a     (coef_sel),
      .b     (basis[idx_q][j]),
      .acc   (out_vector[j])
    );
  end

endmodule

// File: tb/tb_pca_reconstruct_mac.sv
// Directed and randomized checks of pca_reconstruct_mac against a sum-of-products model.
module tb_pca_reconstruct_mac;

  localparam int W  = 64;
  localparam int PN = 32;
  localparam int MN = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] coef_vector [0:MN-1];
  logic [W-1:0] basis       [0:MN-1][0:PN-1];
  logic [W-1:0] out_vector  [0:PN-1];

  int           n_assert = 0;
  int           n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_vec [0:PN-1];

  pca_reconstruct_mac #(.FP_SIZE(W), .PC_NUM(PN), .MIN_PC_NUM(MN)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .coef_vector (coef_vector),
    .basis       (basis),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_vector  (out_vector),
    .busy        (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < MN; i++) begin
      coef_vector[i] = '0;
      for (int j = 0; j < PN; j++) basis[i][j] = '0;
    end
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < MN; i++) begin
      coef_vector[i] = rnd64();
      for (int j = 0; j < PN; j++) basis[i][j] = rnd64();
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: out[j] = sum_i coef[i]*basis[i][j], everything modulo 2^W.
  function automatic void push_expected();
    for (int j = 0; j < PN; j++) begin
      logic [W-1:0] sum;
      sum = '0;
      for (int i = 0; i < MN; i++) sum = sum + coef_vector[i] * basis[i][j];
      exp_q.push_back(sum);
    end
  endfunction

  task automatic check_vec(input string tag);
    for (int j = 0; j < PN; j++) chk($sformatf("%s[%0d]", tag, j), out_vector[j], exp_vec[j]);
  endtask

  task automatic check_zero(input string tag);
    for (int j = 0; j < PN; j++) chk($sformatf("%s[%0d]", tag, j), out_vector[j], '0);
  endtask

  // One job: accept, wait for result, optionally stall `hold` cycles while poking
  // in_valid/coef, then hand off. `scramble` overwrites coef_vector right after accept.
  task automatic run_job(input int hold, input bit scramble);
    int lat;
    chk("idle_in_ready", W'(in_ready), 1);
    push_expected();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("busy_after_accept", W'(busy), 1);
    chk("in_ready_after_accept", W'(in_ready), 0);
    if (scramble) for (int i = 0; i < MN; i++) coef_vector[i] = {8{8'hAA}};
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    chk("latency", W'(lat), MN);
    for (int j = 0; j < PN; j++) exp_vec[j] = exp_q.pop_front();
    check_vec("result");
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      for (int i = 0; i < MN; i++) coef_vector[i] = rnd64();
      step();
      chk("held_out_valid", W'(out_valid), 1);
      chk("held_in_ready", W'(in_ready), 0);
      check_vec("held");
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("post_out_valid", W'(out_valid), 0);
    chk("post_in_ready", W'(in_ready), 1);
    chk("post_busy", W'(busy), 0);
    check_vec("retained");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    repeat (3) step();
    reset = 1'b1;
    chk("rst_in_ready", W'(in_ready), 1);
    chk("rst_out_valid", W'(out_valid), 0);
    chk("rst_busy", W'(busy), 0);
    check_zero("rst_out");

    // Simple job: coef 1..5, basis[i][j] = j+1 -> 15*(j+1)
    for (int i = 0; i < MN; i++) begin
      coef_vector[i] = W'(i + 1);
      for (int j = 0; j < PN; j++) basis[i][j] = W'(j + 1);
    end
    run_job(0, 1'b0);
    chk("simple_out0", out_vector[0], 64'd15);
    chk("simple_out31", out_vector[31], 64'd480);

    // Wrap: product truncation and sum wrap
    clear_inputs();
    coef_vector[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    basis[0][0]    = 64'd2;
    run_job(0, 1'b0);
    chk("wrap_out0", out_vector[0], 64'hFFFF_FFFF_FFFF_FFFE);
    clear_inputs();
    coef_vector[0] = 64'h1_0000_0000;
    basis[0][1]    = 64'h1_0000_0000;
    run_job(0, 1'b0);
    chk("wrap_out1", out_vector[1], 64'd0);

    // Randomized jobs with random stall lengths
    for (int k = 0; k < 4; k++) begin
      randomize_inputs();
      run_job($urandom_range(0, 3), 1'b0);
    end

    // Backpressure: 10 stalled cycles with in_valid high, then the new coefs run
    randomize_inputs();
    run_job(10, 1'b0);
    run_job(0, 1'b0);

    // Reset mid-ACCUM at idx=2 discards the partial sum
    randomize_inputs();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("midrst_in_ready", W'(in_ready), 1);
    chk("midrst_out_valid", W'(out_valid), 0);
    chk("midrst_busy", W'(busy), 0);
    check_zero("midrst_out");
    randomize_inputs();
    coef_vector[0] = 64'd1;
    for (int i = 1; i < MN; i++) coef_vector[i] = '0;
    for (int j = 0; j < PN; j++) basis[0][j] = 64'd7;
    run_job(0, 1'b0);
    chk("after_rst_out5", out_vector[5], 64'd7);

    // Capture: coef changes after accept must not matter
    for (int i = 0; i < MN; i++) begin
      coef_vector[i] = 64'd1;
      for (int j = 0; j < PN; j++) basis[i][j] = 64'd1;
    end
    run_job(0, 1'b1);
    chk("capture_out0", out_vector[0], 64'd5);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
